// File: rtl/ps2_kbd_ctrl.sv
// PS/2 set-2 scan-code controller: drains the receiver FIFO, folds E0/F0 prefixes,
// tracks modifiers, filters typematic repeats and presents one key event at a time.
module ps2_kbd_ctrl #(
  parameter bit FILTER_REPEAT = 1'b1
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       kbd_ready,
  input  logic [7:0] kbd_data,
  input  logic       kbd_overflow,
  output logic       kbd_nextdata_n,
  output logic       key_valid,
  input  logic       key_ack,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic [7:0] key_ascii,
  output logic       shift,
  output logic       ctrl,
  output logic       caps,
  output logic       err_overflow
);

  typedef enum logic [1:0] {IDLE, POP, DECODE, EMIT} state_t;

  state_t     state_q, state_d;
  logic [7:0] byte_r;
  logic       ext_p, brk_p;
  logic       held_v, held_ext;
  logic [7:0] held_code;
  logic       is_e0, is_f0, is_ign, is_ev, rpt;
  logic [7:0] asc;

  // ASCII uses the modifier state as it was before this byte is applied.
  function automatic logic [7:0] to_ascii(input logic [7:0] code, input logic ext, brk,
                                          input logic sh, ct, cp);
    logic [4:0] li;
    logic       hit;
    logic [7:0] a;
    li  = '0;
    hit = 1'b1;
    a   = 8'h00;
    case (code)
      8'h1C: li = 5'd0;  8'h32: li = 5'd1;  8'h21: li = 5'd2;  8'h23: li = 5'd3;
      8'h24: li = 5'd4;  8'h2B: li = 5'd5;  8'h34: li = 5'd6;  8'h33: li = 5'd7;
      8'h43: li = 5'd8;  8'h3B: li = 5'd9;  8'h42: li = 5'd10; 8'h4B: li = 5'd11;
      8'h3A: li = 5'd12; 8'h31: li = 5'd13; 8'h44: li = 5'd14; 8'h4D: li = 5'd15;
      8'h15: li = 5'd16; 8'h2D: li = 5'd17; 8'h1B: li = 5'd18; 8'h2C: li = 5'd19;
      8'h3C: li = 5'd20; 8'h2A: li = 5'd21; 8'h1D: li = 5'd22; 8'h22: li = 5'd23;
      8'h35: li = 5'd24; 8'h1A: li = 5'd25;
      default: hit = 1'b0;
    endcase
    if (hit)
      a = ct ? ({3'b000, li} + 8'd1) : (((sh ^ cp) ? 8'h41 : 8'h61) + {3'b000, li});
    else
      case (code)
        8'h45: a = sh ? 8'h29 : 8'h30;
        8'h16: a = sh ? 8'h21 : 8'h31;
        8'h1E: a = sh ? 8'h40 : 8'h32;
        8'h26: a = sh ? 8'h23 : 8'h33;
        8'h25: a = sh ? 8'h24 : 8'h34;
        8'h2E: a = sh ? 8'h25 : 8'h35;
        8'h36: a = sh ? 8'h5E : 8'h36;
        8'h3D: a = sh ? 8'h26 : 8'h37;
        8'h3E: a = sh ? 8'h2A : 8'h38;
        8'h46: a = sh ? 8'h28 : 8'h39;
        8'h29: a = 8'h20;
        8'h5A: a = 8'h0D;
        8'h66: a = 8'h08;
        8'h0D: a = 8'h09;
        8'h76: a = 8'h1B;
        default: a = 8'h00;
      endcase
    if (brk)      a = 8'h00;
    else if (ext) a = (code == 8'h5A) ? 8'h0D : 8'h00;
    return a;
  endfunction

  always_comb begin
    is_e0   = (byte_r == 8'hE0);
    is_f0   = (byte_r == 8'hF0);
    is_ign  = byte_r inside {8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hEE};
    is_ev   = !is_e0 && !is_f0 && !is_ign;
    rpt     = FILTER_REPEAT && !brk_p && held_v && (held_ext == ext_p) && (held_code == byte_r);
    asc     = to_ascii(byte_r, ext_p, brk_p, shift, ctrl, caps);
    state_d = state_q;
    case (state_q)
      IDLE:    if (kbd_ready) state_d = POP;
      POP:     state_d = DECODE;
      DECODE:  state_d = (is_ev && !rpt) ? EMIT : IDLE;
      EMIT:    if (key_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clrn) begin
      state_q        <= IDLE;
      kbd_nextdata_n <= 1'b1;
      byte_r         <= '0;
      ext_p          <= 1'b0;
      brk_p          <= 1'b0;
      held_v         <= 1'b0;
      held_ext       <= 1'b0;
      held_code      <= '0;
      key_valid      <= 1'b0;
      key_code       <= '0;
      key_ext        <= 1'b0;
      key_break      <= 1'b0;
      key_ascii      <= '0;
      shift          <= 1'b0;
      ctrl           <= 1'b0;
      caps           <= 1'b0;
      err_overflow   <= 1'b0;
    end else begin
      state_q        <= state_d;
      kbd_nextdata_n <= (state_d != POP);
      if (kbd_overflow) err_overflow <= 1'b1;
      if (state_q == POP) byte_r <= kbd_data;
      if (state_q == EMIT && key_ack) key_valid <= 1'b0;
      if (state_q == DECODE) begin
        if (is_e0) ext_p <= 1'b1;
        else if (is_f0) brk_p <= 1'b1;
        else begin
          ext_p <= 1'b0;
          brk_p <= 1'b0;
        end
        if (is_ev) begin
          if (!ext_p && (byte_r == 8'h12 || byte_r == 8'h59)) shift <= !brk_p;
          if (byte_r == 8'h14) ctrl <= !brk_p;
          if (!ext_p && byte_r == 8'h58 && !brk_p && !rpt) caps <= !caps;
          if (FILTER_REPEAT) begin
            if (brk_p) begin
              if (held_v && held_ext == ext_p && held_code == byte_r) held_v <= 1'b0;
            end else if (!rpt) begin
              held_v    <= 1'b1;
              held_ext  <= ext_p;
              held_code <= byte_r;
            end
          end
          if (!rpt) begin
            key_valid <= 1'b1;
            key_code  <= byte_r;
            key_ext   <= ext_p;
            key_break <= brk_p;
            key_ascii <= asc;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Bench for ps2_kbd_ctrl: two instances (repeat filter on/off), each fed by a small
// FIFO model that pops on the active-low strobe.
module tb_ps2_kbd_ctrl;
  logic clk = 1'b0;
  logic clrn;
  logic [1:0] rdy, nxt_n, kv, ka, kext, kbrk, ovf, shf, ctl, cps, eovf;
  logic [1:0][7:0] dat, kc, kasc;

  logic [7:0] mem [2][256];
  logic [7:0] head [2] = '{8'd0, 8'd0};
  logic [7:0] tail [2] = '{8'd0, 8'd0};
  int pops [2] = '{0, 0};
  int n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  ps2_kbd_ctrl #(.FILTER_REPEAT(1'b1)) u0 (
    .clk(clk), .clrn(clrn), .kbd_ready(rdy[0]), .kbd_data(dat[0]), .kbd_overflow(ovf[0]),
    .kbd_nextdata_n(nxt_n[0]), .key_valid(kv[0]), .key_ack(ka[0]), .key_code(kc[0]),
    .key_ext(kext[0]), .key_break(kbrk[0]), .key_ascii(kasc[0]), .shift(shf[0]),
    .ctrl(ctl[0]), .caps(cps[0]), .err_overflow(eovf[0]));

  ps2_kbd_ctrl #(.FILTER_REPEAT(1'b0)) u1 (
    .clk(clk), .clrn(clrn), .kbd_ready(rdy[1]), .kbd_data(dat[1]), .kbd_overflow(ovf[1]),
    .kbd_nextdata_n(nxt_n[1]), .key_valid(kv[1]), .key_ack(ka[1]), .key_code(kc[1]),
    .key_ext(kext[1]), .key_break(kbrk[1]), .key_ascii(kasc[1]), .shift(shf[1]),
    .ctrl(ctl[1]), .caps(cps[1]), .err_overflow(eovf[1]));

  always_comb
    for (int i = 0; i < 2; i++) begin
      rdy[i] = (head[i] != tail[i]);
      dat[i] = mem[i][head[i]];
    end

  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (!nxt_n[i]) begin
        if (head[i] != tail[i]) head[i] <= head[i] + 8'd1;
        pops[i] <= pops[i] + 1;
      end

  typedef struct {
    int         n;
    logic [7:0] b0, b1, b2, code;
    logic       ext, brk;
    logic [7:0] asc;
    logic       s, c, k;
  } vec_t;
  vec_t tv[$];

  task automatic add(input int n, input logic [7:0] b0, b1, b2, code, input logic ext, brk,
                     input logic [7:0] asc, input logic s, c, k);
    vec_t v;
    v.n = n; v.b0 = b0; v.b1 = b1; v.b2 = b2; v.code = code;
    v.ext = ext; v.brk = brk; v.asc = asc; v.s = s; v.c = c; v.k = k;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int d, input logic [7:0] b);
    mem[d][tail[d]] = b;
    tail[d] = tail[d] + 8'd1;
  endtask

  task automatic wait_valid(input int d, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!kv[d] && k < 200);
    if (!kv[d]) chk("event timeout", 32'd0, 32'd1);
  endtask

  task automatic ack(input int d);
    ka[d] = 1'b1;
    @(negedge clk);
    ka[d] = 1'b0;
    chk("valid drop after ack", {31'd0, kv[d]}, 32'd0);
  endtask

  task automatic collect(input int d, output int cnt, output logic [7:0] pat);
    cnt = 0;
    pat = '0;
    repeat (150) begin
      @(negedge clk);
      if (ka[d]) ka[d] = 1'b0;
      else if (kv[d]) begin
        if (cnt < 8) pat[cnt] = kbrk[d];
        cnt++;
        ka[d] = 1'b1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, p0, cnt, bad;
    logic [7:0] pat, c0, a0;
    logic [7:0] bpc [4];
    logic [7:0] bpa [4];
    bpc = '{8'h15, 8'h2D, 8'h1B, 8'h2C};
    bpa = '{8'h71, 8'h72, 8'h73, 8'h74};

    //   n  b0     b1     b2     code   ext brk asc    s c k
    add(1, 8'h1C, 8'h00, 8'h00, 8'h1C, 0, 0, 8'h61, 0, 0, 0);
    add(2, 8'hF0, 8'h1C, 8'h00, 8'h1C, 0, 1, 8'h00, 0, 0, 0);
    add(1, 8'h12, 8'h00, 8'h00, 8'h12, 0, 0, 8'h00, 1, 0, 0);
    add(1, 8'h1C, 8'h00, 8'h00, 8'h1C, 0, 0, 8'h41, 1, 0, 0);
    add(2, 8'hF0, 8'h12, 8'h00, 8'h12, 0, 1, 8'h00, 0, 0, 0);
    add(1, 8'h58, 8'h00, 8'h00, 8'h58, 0, 0, 8'h00, 0, 0, 1);
    add(2, 8'hF0, 8'h58, 8'h00, 8'h58, 0, 1, 8'h00, 0, 0, 1);
    add(1, 8'h1C, 8'h00, 8'h00, 8'h1C, 0, 0, 8'h41, 0, 0, 1);
    add(1, 8'h12, 8'h00, 8'h00, 8'h12, 0, 0, 8'h00, 1, 0, 1);
    add(1, 8'h1C, 8'h00, 8'h00, 8'h1C, 0, 0, 8'h61, 1, 0, 1);
    add(2, 8'hF0, 8'h12, 8'h00, 8'h12, 0, 1, 8'h00, 0, 0, 1);
    add(1, 8'h16, 8'h00, 8'h00, 8'h16, 0, 0, 8'h31, 0, 0, 1);
    add(1, 8'h12, 8'h00, 8'h00, 8'h12, 0, 0, 8'h00, 1, 0, 1);
    add(1, 8'h16, 8'h00, 8'h00, 8'h16, 0, 0, 8'h21, 1, 0, 1);
    add(2, 8'hF0, 8'h12, 8'h00, 8'h12, 0, 1, 8'h00, 0, 0, 1);
    add(2, 8'hE0, 8'h5A, 8'h00, 8'h5A, 1, 0, 8'h0D, 0, 0, 1);
    add(1, 8'h14, 8'h00, 8'h00, 8'h14, 0, 0, 8'h00, 0, 1, 1);
    add(1, 8'h1C, 8'h00, 8'h00, 8'h1C, 0, 0, 8'h01, 0, 1, 1);
    add(3, 8'hE0, 8'hF0, 8'h14, 8'h14, 1, 1, 8'h00, 0, 0, 1);
    add(1, 8'h58, 8'h00, 8'h00, 8'h58, 0, 0, 8'h00, 0, 0, 0);
    add(2, 8'hF0, 8'h58, 8'h00, 8'h58, 0, 1, 8'h00, 0, 0, 0);
    add(1, 8'h29, 8'h00, 8'h00, 8'h29, 0, 0, 8'h20, 0, 0, 0);
    add(1, 8'h66, 8'h00, 8'h00, 8'h66, 0, 0, 8'h08, 0, 0, 0);
    add(1, 8'h76, 8'h00, 8'h00, 8'h76, 0, 0, 8'h1B, 0, 0, 0);
    add(1, 8'h0D, 8'h00, 8'h00, 8'h0D, 0, 0, 8'h09, 0, 0, 0);
    add(1, 8'h1A, 8'h00, 8'h00, 8'h1A, 0, 0, 8'h7A, 0, 0, 0);
    add(2, 8'hAA, 8'h1D, 8'h00, 8'h1D, 0, 0, 8'h77, 0, 0, 0);
    add(3, 8'hE0, 8'h00, 8'h1C, 8'h1C, 0, 0, 8'h61, 0, 0, 0);

    clrn = 1'b1; ka = '0; ovf = '0;
    repeat (3) @(negedge clk);
    chk("rst nextdata_n", {31'd0, nxt_n[0]}, 32'd1);
    chk("rst valid/ext/brk", {29'd0, kv[0], kext[0], kbrk[0]}, 32'd0);
    chk("rst code/ascii", {16'd0, kc[0], kasc[0]}, 32'd0);
    chk("rst mods/err", {28'd0, shf[0], ctl[0], cps[0], eovf[0]}, 32'd0);
    clrn = 1'b0;
    @(negedge clk);

    // single-byte latency and pop strobe timing
    p0 = pops[0];
    push(0, 8'h2C);
    @(negedge clk);
    chk("pop strobe at T+1", {31'd0, nxt_n[0]}, 32'd0);
    @(negedge clk);
    chk("valid low in decode", {31'd0, kv[0]}, 32'd0);
    @(negedge clk);
    chk("valid at T+3", {31'd0, kv[0]}, 32'd1);
    chk("latency pops", pops[0] - p0, 32'd1);
    ack(0);
    push(0, 8'hE0); push(0, 8'hF0); push(0, 8'h2C);
    wait_valid(0, k);
    chk("3-byte latency", k, 32'd9);
    ack(0);

    foreach (tv[i]) begin
      p0 = pops[0];
      push(0, tv[i].b0);
      if (tv[i].n > 1) push(0, tv[i].b1);
      if (tv[i].n > 2) push(0, tv[i].b2);
      wait_valid(0, k);
      chk($sformatf("r%0d code", i), {24'd0, kc[0]}, {24'd0, tv[i].code});
      chk($sformatf("r%0d ext/brk", i), {30'd0, kext[0], kbrk[0]}, {30'd0, tv[i].ext, tv[i].brk});
      chk($sformatf("r%0d ascii", i), {24'd0, kasc[0]}, {24'd0, tv[i].asc});
      chk($sformatf("r%0d mods", i), {29'd0, shf[0], ctl[0], cps[0]},
          {29'd0, tv[i].s, tv[i].c, tv[i].k});
      chk($sformatf("r%0d pops", i), pops[0] - p0, tv[i].n);
      ack(0);
    end

    // overflow is sticky
    ovf[0] = 1'b1;
    @(negedge clk);
    ovf[0] = 1'b0;
    chk("err_overflow set", {31'd0, eovf[0]}, 32'd1);
    repeat (10) @(negedge clk);
    chk("err_overflow held", {31'd0, eovf[0]}, 32'd1);

    // reset during EMIT after an E0 prefix drops the event
    push(0, 8'h14);
    wait_valid(0, k);
    ack(0);
    push(0, 8'hE0); push(0, 8'h5A);
    wait_valid(0, k);
    chk("pre-reset ctrl/ext", {30'd0, ctl[0], kext[0]}, 32'd3);
    clrn = 1'b1;
    @(negedge clk);
    clrn = 1'b0;
    chk("mid rst valid/ext/brk", {29'd0, kv[0], kext[0], kbrk[0]}, 32'd0);
    chk("mid rst code/ascii", {16'd0, kc[0], kasc[0]}, 32'd0);
    chk("mid rst mods/err", {28'd0, shf[0], ctl[0], cps[0], eovf[0]}, 32'd0);
    chk("mid rst nextdata_n", {31'd0, nxt_n[0]}, 32'd1);

    // repeat filter on / off
    push(0, 8'h1C); push(0, 8'h1C); push(0, 8'h1C); push(0, 8'hF0); push(0, 8'h1C); push(0, 8'h1C);
    collect(0, cnt, pat);
    chk("filter on count", cnt, 32'd3);
    chk("filter on break pattern", {24'd0, pat}, 32'h02);
    push(1, 8'h1C); push(1, 8'h1C); push(1, 8'h1C); push(1, 8'hF0); push(1, 8'h1C); push(1, 8'h1C);
    collect(1, cnt, pat);
    chk("filter off count", cnt, 32'd5);
    chk("filter off break pattern", {24'd0, pat}, 32'h08);

    // backpressure: consumer stalls, nothing else is popped
    for (int i = 0; i < 4; i++) push(0, bpc[i]);
    wait_valid(0, k);
    c0 = kc[0]; a0 = kasc[0]; p0 = pops[0]; bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (!kv[0] || kc[0] !== c0 || kasc[0] !== a0 || !nxt_n[0]) bad = 1;
    end
    chk("bp stable 50 cycles", bad, 32'd0);
    chk("bp no pops", pops[0] - p0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) wait_valid(0, k);
      chk($sformatf("bp%0d code", i), {24'd0, kc[0]}, {24'd0, bpc[i]});
      chk($sformatf("bp%0d ascii", i), {24'd0, kasc[0]}, {24'd0, bpa[i]});
      ack(0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
